// File: rtl/pc_stack_if.sv
// Command and status bundle between the control unit and pc_stack.
// The control unit (master) drives the command strobes. pc_stack (slave)
// returns the registered PC and the return-stack status.
// The shared data bus pc_inout is not part of this bundle. It stays a
// plain inout on pc_stack because other blocks also sit on that bus.
//   w, r, i, b, call, ret : command strobes, master -> slave
//   pc_out                : registered PC, slave -> master
//   sp, full, empty, err  : return-stack status, slave -> master
interface pc_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic             w;
    logic             r;
    logic             i;
    logic             b;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc_out;
    logic [SP_W-1:0]  sp;
    logic             full;
    logic             empty;
    logic             err;

    modport master (
        output w, r, i, b, call, ret,
        input  pc_out, sp, full, empty, err
    );

    modport slave (
        input  w, r, i, b, call, ret,
        output pc_out, sp, full, empty, err
    );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack.
// It supports load, bus read, increment, PC-relative branch, call and return.
// One command executes per rising edge, in this priority order:
// w > call > ret > b > i.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high
//   ctl      : command strobes in; pc_out and stack status out
//   pc_inout : shared data bus. It is sampled by w, call and b.
//              It is driven with the PC for r, but only when no
//              bus-sampling command is asserted in the same cycle.
module pc_stack #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int RESET_VALUE = 0,
    parameter int INC_STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    pc_stack_if.slave        ctl,
    inout  wire  [WIDTH-1:0] pc_inout
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] pc;
    logic [SP_W-1:0]  sp;
    logic             err;
    logic [WIDTH-1:0] stack [DEPTH];

    logic [WIDTH-1:0] next_pc;
    logic [SP_W-1:0]  next_sp;
    logic             next_err;
    logic             push;
    logic [WIDTH-1:0] inc_pc;
    logic [WIDTH-1:0] top;
    logic             full;
    logic             empty;
    logic             drive;

    assign full   = (sp == SP_W'(DEPTH));
    assign empty  = (sp == '0);
    assign inc_pc = pc + WIDTH'(INC_STEP);

    // Top of stack is stack[sp-1]. A compare loop avoids indexing with an
    // sp value that can be one past the last entry.
    always_comb begin
        top = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sp == SP_W'(k + 1)) top = stack[k];
        end
    end

    always_comb begin
        next_pc  = pc;
        next_sp  = sp;
        next_err = err;
        push     = 1'b0;
        if (ctl.w) begin
            next_pc = pc_inout;
        end else if (ctl.call) begin
            if (!full) begin
                push    = 1'b1;
                next_sp = sp + 1'b1;
                next_pc = pc_inout;
            end else begin
                next_err = 1'b1;
            end
        end else if (ctl.ret) begin
            if (!empty) begin
                next_pc = top;
                next_sp = sp - 1'b1;
            end else begin
                next_err = 1'b1;
            end
        end else if (ctl.b) begin
            // Two's-complement add, so a negative offset wraps mod 2^WIDTH.
            next_pc = pc + pc_inout;
        end else if (ctl.i) begin
            next_pc = inc_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc  <= WIDTH'(RESET_VALUE);
            sp  <= '0;
            err <= 1'b0;
        end else begin
            pc  <= next_pc;
            sp  <= next_sp;
            err <= next_err;
        end
    end

    // Entries are never cleared. Anything at or above sp is don't-care,
    // so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (sp == SP_W'(k)) stack[k] <= inc_pc;
            end
        end
    end

    // Bus-sampling commands win over r, so the bus is never contended.
    assign drive    = ctl.r && !ctl.w && !ctl.call && !ctl.b && !reset;
    assign pc_inout = drive ? pc : {WIDTH{1'bz}};

    assign ctl.pc_out = pc;
    assign ctl.sp     = sp;
    assign ctl.full   = full;
    assign ctl.empty  = empty;
    assign ctl.err    = err;
endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tb_val = 8'h00;
    logic       tb_en = 1'b0;
    wire  [7:0] bus;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] m_pc = 8'h00;
    logic [7:0] m_q[$];
    logic       m_err = 1'b0;

    pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ctl_if ();

    pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(0), .INC_STEP(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .ctl      (ctl_if.slave),
        .pc_inout (bus)
    );

    // An undriven bus reads all ones.
    pullup (bus[0]); pullup (bus[1]); pullup (bus[2]); pullup (bus[3]);
    pullup (bus[4]); pullup (bus[5]); pullup (bus[6]); pullup (bus[7]);
    assign bus = tb_en ? tb_val : 8'bz;

    always #25 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set(input logic w_, input logic r_, input logic i_, input logic b_,
                       input logic c_, input logic rt_, input logic [7:0] v, input logic en);
        ctl_if.w = w_; ctl_if.r = r_; ctl_if.i = i_; ctl_if.b = b_;
        ctl_if.call = c_; ctl_if.ret = rt_;
        tb_val = v; tb_en = en;
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_q.delete();
        m_err = 1'b0;
    endtask

    // Advance one edge and apply the command rules to the model.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (ctl_if.w) m_pc = tb_val;
            else if (ctl_if.call) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(m_pc + 8'd1);
                    m_pc = tb_val;
                end else m_err = 1'b1;
            end else if (ctl_if.ret) begin
                if (m_q.size() > 0) m_pc = m_q.pop_back();
                else m_err = 1'b1;
            end else if (ctl_if.b) m_pc = m_pc + tb_val;
            else if (ctl_if.i) m_pc = m_pc + 8'd1;
        end
        #1;
    endtask

    task automatic cyc(input logic w_, input logic r_, input logic i_, input logic b_,
                       input logic c_, input logic rt_, input logic [7:0] v);
        set(w_, r_, i_, b_, c_, rt_, v, w_ | b_ | c_);
        tick();
    endtask

    task automatic idle();
        set(0, 0, 0, 0, 0, 0, 8'h00, 1'b0);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic       drv;
        logic [7:0] exp_bus;
        drv = ctl_if.r && !ctl_if.w && !ctl_if.call && !ctl_if.b && !reset;
        exp_bus = drv ? m_pc : (tb_en ? tb_val : 8'hFF);
        check("pc_out", ctl_if.pc_out, m_pc);
        check("sp", ctl_if.sp, m_q.size());
        check("full", ctl_if.full, m_q.size() == DEPTH);
        check("empty", ctl_if.empty, m_q.size() == 0);
        check("err", ctl_if.err, m_err);
        check("bus", bus, exp_bus);
    end

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: reset state, read, release
        check("t1_pc", ctl_if.pc_out, 8'h00);
        set(0, 1, 0, 0, 0, 0, 8'h00, 1'b0);
        #5 check("t1_bus", bus, 8'h00);
        tick();
        idle();
        #5 check("t1_busz", bus, 8'hFF);
        tick();

        // 2: load, read, increment
        cyc(1, 0, 0, 0, 0, 0, 8'h77);
        check("t2_load", ctl_if.pc_out, 8'h77);
        set(0, 1, 0, 0, 0, 0, 8'h00, 1'b0);
        #5 check("t2_bus", bus, 8'h77);
        tick();
        cyc(0, 0, 1, 0, 0, 0, 8'h00);
        check("t2_inc", ctl_if.pc_out, 8'h78);

        // 1 (cont.): asynchronous reset mid-cycle
        idle();
        #10 reset = 1'b1;
        model_reset();
        #1 check("t1_async", ctl_if.pc_out, 8'h00);
        #5 reset = 1'b0;
        tick();

        // 3: wrap and branch
        cyc(1, 0, 0, 0, 0, 0, 8'hFF);
        cyc(0, 0, 1, 0, 0, 0, 8'h00);
        check("t3_wrap", ctl_if.pc_out, 8'h00);
        cyc(1, 0, 0, 0, 0, 0, 8'h10);
        cyc(0, 0, 0, 1, 0, 0, 8'hFC);
        check("t3_bneg", ctl_if.pc_out, 8'h0C);
        cyc(0, 0, 0, 1, 0, 0, 8'h05);
        check("t3_bpos", ctl_if.pc_out, 8'h11);
        cyc(1, 0, 0, 0, 0, 0, 8'hFE);
        cyc(0, 0, 0, 1, 0, 0, 8'h04);
        check("t3_bwrap", ctl_if.pc_out, 8'h02);

        // 4: stack round trip with overflow
        cyc(1, 0, 0, 0, 0, 0, 8'h20);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] tgt;
            tgt = 8'h40 + 8'(k * 16);
            cyc(0, 0, 0, 0, 1, 0, tgt);
            check("t4_sp", ctl_if.sp, k + 1);
        end
        check("t4_full", ctl_if.full, 1);
        check("t4_pc", ctl_if.pc_out, 8'h70);
        cyc(0, 0, 0, 0, 1, 0, 8'h80);
        check("t4_err", ctl_if.err, 1);
        check("t4_pcov", ctl_if.pc_out, 8'h70);
        check("t4_spov", ctl_if.sp, 4);
        begin
            logic [7:0] exp_ret [4];
            exp_ret[0] = 8'h61; exp_ret[1] = 8'h51; exp_ret[2] = 8'h41; exp_ret[3] = 8'h21;
            for (int k = 0; k < 4; k++) begin
                cyc(0, 0, 0, 0, 0, 1, 8'h00);
                check("t4_ret", ctl_if.pc_out, exp_ret[k]);
            end
        end
        check("t4_empty", ctl_if.empty, 1);

        // 5: underflow, sticky err
        idle();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, 8'h44);
        cyc(0, 0, 0, 0, 0, 1, 8'h00);
        check("t5_err", ctl_if.err, 1);
        check("t5_pc", ctl_if.pc_out, 8'h44);
        check("t5_sp", ctl_if.sp, 0);
        cyc(0, 0, 0, 0, 1, 0, 8'h30);
        check("t5_sticky", ctl_if.err, 1);
        check("t5_sp1", ctl_if.sp, 1);
        idle();
        reset = 1'b1;
        model_reset();
        tick();
        check("t5_clr", ctl_if.err, 0);
        check("t5_spclr", ctl_if.sp, 0);
        reset = 1'b0;

        // 6: simultaneous strobes
        cyc(1, 0, 1, 0, 0, 0, 8'h33);
        check("t6_wi", ctl_if.pc_out, 8'h33);
        cyc(0, 0, 0, 0, 1, 1, 8'h90);
        check("t6_callret_pc", ctl_if.pc_out, 8'h90);
        check("t6_callret_sp", ctl_if.sp, 1);
        set(1, 1, 0, 0, 0, 0, 8'h5A, 1'b1);
        #5 check("t6_rw_bus", bus, 8'h5A);
        tick();
        check("t6_rw_pc", ctl_if.pc_out, 8'h5A);
        cyc(1, 0, 0, 0, 0, 0, 8'h05);
        set(0, 1, 1, 0, 0, 0, 8'h00, 1'b0);
        #5 check("t6_ri_bus", bus, 8'h05);
        tick();
        check("t6_ri_pc", ctl_if.pc_out, 8'h06);
        cyc(0, 0, 0, 0, 0, 1, 8'h00);
        check("t6_ret", ctl_if.pc_out, 8'h34);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with a hardware return-address stack for the DAPA datapath. It keeps the load (`w`), bus read (`r`) and increment (`i`) operations of the 8-bit PC over the shared bidirectional bus. It adds a configurable width, a configurable increment step, PC-relative branching, and call/return through a LIFO of return addresses with full, empty and error status. It sits between the control unit (command strobes) and the internal data bus (`pc_inout`), and drives the instruction-memory address (`pc_out`).

## Interface
- `WIDTH`, 8: PC and bus width in bits (≥ 2).
- `DEPTH`, 4: return-stack entries (≥ 1).
- `RESET_VALUE`, 0: PC value after reset.
- `INC_STEP`, 1: amount added by `i` and used for return addresses.

Ports:
- `clk`  in  1  system clock, rising edge active.
- `reset`  in  1  asynchronous, active-high reset.
- `w`  in  1  load PC from `pc_inout`.
- `r`  in  1  drive current PC onto `pc_inout`.
- `i`  in  1  increment PC by `INC_STEP`.
- `b`  in  1  relative branch; `pc_inout` holds a signed two's-complement offset.
- `call`  in  1  push return address, jump to the `pc_inout` target.
- `ret`  in  1  pop the stack into the PC.
- `pc_inout`  inout  WIDTH  shared data bus; high-Z unless this block is driving it.
- `pc_out`  out  WIDTH  registered PC value.
- `sp`  out  $clog2(DEPTH+1)  number of stacked entries.
- `full`  out  1  `sp == DEPTH`.
- `empty`  out  1  `sp == 0`.
- `err`  out  1  sticky flag for stack overflow or underflow.

## Operation
- One command executes per rising edge. Fixed priority: `w` > `call` > `ret` > `b` > `i`. Lower-priority strobes asserted in the same cycle are ignored with no side effects.
- `w`: the PC takes the value on `pc_inout`. The stack is unchanged.
- `call` when not full:
  - `stack[sp]` takes `pc + INC_STEP`, computed mod 2^WIDTH.
  - `sp` increments.
  - The PC takes the value on `pc_inout`.
- `call` when full: no push, PC unchanged, `err` set to 1.
- `ret` when not empty: the PC takes `stack[sp-1]` and `sp` decrements.
- `ret` when empty: PC unchanged, `err` set to 1.
- `b`: the PC takes `pc + pc_inout`. The offset is treated as signed WIDTH-bit. The result wraps mod 2^WIDTH; there is no overflow flag.
- `i`: the PC takes `pc + INC_STEP`, mod 2^WIDTH. At 2^WIDTH−1 with `INC_STEP = 1` it wraps to 0.
- `r` drives `pc_inout` with the registered PC only when none of `w`, `call` or `b` is asserted in the same cycle. Those commands sample the bus, so with any of them the block leaves `pc_inout` high-Z. `r` alone, or with `i` or `ret`, drives the current (pre-edge) PC.
- `err` stays at 1 until reset. It is not cleared by later valid operations.
- Stack entries are not cleared on pop. Their contents above `sp` are don't-care.

## Timing
- Reset is asynchronous and takes effect immediately when `reset` rises, independent of `clk`. Values while reset is high:
  - `pc_out = RESET_VALUE`
  - `sp = 0`, `empty = 1`, `full = 0`, `err = 0`
  - `pc_inout` high-Z
- All strobes are ignored while `reset` is high. Operation resumes at the first rising edge after `reset` falls.
- Reset during a call/return sequence discards all stacked entries.
- `pc_out`, `sp`, `full`, `empty` and `err` are registered and update on the same edge that samples the command. Latency is one cycle from strobe to new value.
- The `r` bus drive is combinational from `r` and the registered PC. It is valid within the same cycle and is released (high-Z) combinationally when `r` falls.
- `full` and `empty` are derived from the registered `sp`. They never glitch relative to `sp`.
- Back-to-back `call` or `ret` on consecutive cycles is supported at full rate.

## Test plan
Defaults for all scenarios: `WIDTH=8`, `DEPTH=4`, `RESET_VALUE=0`, `INC_STEP=1`, 50 ns clock.

1. Reset, then `r=1` for one cycle.
   - `pc_out=8'h00` and the bus reads `8'h00` while `r` is high.
   - The bus returns to high-Z when `r=0`.
   - Assert `reset` mid-cycle: `pc_out` goes to 0 before the next edge.
2. Bus `8'h77` with `w=1`, then `r=1`.
   - `pc_out=8'h77` after the edge.
   - The bus reads `8'h77`.
   - `i=1` gives `8'h78`.
3. Wrap and branch:
   - `w` `8'hFF`, then `i` → `8'h00`.
   - `w` `8'h10`, `b` offset `8'hFC` → `8'h0C`.
   - `b` offset `8'h05` → `8'h11`.
   - `w` `8'hFE`, `b` offset `8'h04` → `8'h02`.
4. Stack round trip from PC `8'h20`: `call` targets `8'h40`, `8'h50`, `8'h60`, `8'h70`.
   - `sp` goes 1..4, `full=1`, `pc_out=8'h70`.
   - A fifth `call` to `8'h80` sets `err=1`, leaves the PC at `8'h70` and `sp=4`.
   - Four `ret` give `8'h61`, `8'h51`, `8'h41`, `8'h21`, with `empty=1`.
5. With `empty=1`, `ret`: `err=1`, PC unchanged, `sp=0`. `err` stays 1 through a later valid `call` until reset.
6. Simultaneous strobes:
   - `w`+`i` with bus `8'h33`: PC=`8'h33`.
   - `call`+`ret`: the push occurs, no pop.
   - `r`+`w`: the block never drives the bus (test bench-driven value is seen unmodified).
   - `r`+`i` at PC `8'h05`: the bus shows `8'h05` and the PC becomes `8'h06`.
